// File: rtl/psum_init_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_init_gen_pkg
// Description : Shared types and sizes for the partial-sum initial generator.
//               Covers operating modes, pipeline stages, ofmap sizes and the
//               psum packet layout.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_init_gen_pkg;

    // Packet sizing; the generator's PSUM_W / IDX_W / FILTER_NUM defaults match these
    localparam int PKG_PSUM_W     = 16;
    localparam int PKG_IDX_W      = 6;
    localparam int PKG_FILTER_NUM = 4;
    localparam int PKG_FILT_W     = $clog2(PKG_FILTER_NUM);

    // Output feature-map sizes (positions per sweep) for each layer
    localparam int L1_OFMAP_SIZE  = 32;
    localparam int L2_OFMAP_SIZE  = 16;
    localparam int L3_OFMAP_SIZE  = 8;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } OP_MODE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CONV  = 2'd2,
        STORE = 2'd3
    } OP_STAGE;

    typedef struct packed {
        logic                  valid;
        logic [PKG_FILT_W-1:0] filter_idx;
        logic [PKG_IDX_W-1:0]  psum_idx;
        logic [PKG_PSUM_W-1:0] psum;
    } PSUM_PACKET;

    // Last ofmap position index of a sweep for the given mode
    function automatic logic [PKG_IDX_W-1:0] idx_max_for(input OP_MODE m);
        logic [PKG_IDX_W-1:0] r;
        case (m)
            MODE3:   r = PKG_IDX_W'(L2_OFMAP_SIZE - 1);
            MODE4:   r = PKG_IDX_W'(L3_OFMAP_SIZE - 1);
            default: r = PKG_IDX_W'(L1_OFMAP_SIZE - 1);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_init_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_init_gen_if
// Description : Packet handshake between the psum generator (master) and its
//               consumer (slave), plus sweep status.
// Revision    : 1.0 - initial release
// ============================================================================
interface psum_init_gen_if;
    import psum_init_gen_pkg::*;

    PSUM_PACKET psum_out;
    logic       psum_ack;
    logic       sweep_done;
    logic       busy;

    modport master (
        output psum_out,
        output sweep_done,
        output busy,
        input  psum_ack
    );

    modport slave (
        input  psum_out,
        input  sweep_done,
        input  busy,
        output psum_ack
    );

endinterface
`default_nettype wire

// File: rtl/psum_bias_rf.sv
`default_nettype none
// ============================================================================
// Module      : psum_bias_rf
// Description : Per-filter bias register file. One synchronous write port,
//               one asynchronous read port returning the pre-write value.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_bias_rf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [DATA_W-1:0]        wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Next register contents: only the addressed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register update; reset clears every bias to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[raddr];

endmodule
`default_nettype wire

// File: rtl/psum_init_gen.sv
`default_nettype none
// ============================================================================
// Module      : psum_init_gen
// Description : Emits initial partial sums (bias or zero) for every
//               (ofmap position, filter) pair of a sweep, filter index
//               innermost, under a valid/ack handshake. Emits only in the
//               CONV stage; restarts on conv_continue or change_mode.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_init_gen
    import psum_init_gen_pkg::*;
#(
    parameter int PSUM_W     = 16,
    parameter int FILTER_NUM = 4,
    parameter int IDX_W      = 6
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    psum_init_gen_if.master                    bus,
    input  wire OP_MODE                        mode_in,
    input  wire logic                          change_mode,
    input  wire logic                          conv_continue,
    input  wire OP_STAGE                       op_stage_in,
    input  wire logic                          bias_en,
    input  wire logic                          bias_we,
    input  wire logic [$clog2(FILTER_NUM)-1:0] bias_addr,
    input  wire logic [PSUM_W-1:0]             bias_data
);

    localparam int FILT_W = $clog2(FILTER_NUM);

    localparam logic [0:0] ST_SEND = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_NUM - 1);

    logic [0:0]        state_q,       state_d;
    logic [FILT_W-1:0] filter_idx_q,  filter_idx_d;
    logic [IDX_W-1:0]  psum_idx_q,    psum_idx_d;
    OP_MODE            cur_mode_q,    cur_mode_d;
    logic              sweep_done_q,  sweep_done_d;

    logic [IDX_W-1:0]  idx_max;
    logic              valid;
    logic              xfer;
    logic              restart;
    logic [PSUM_W-1:0] bias_rd;
    PSUM_PACKET        pkt;

    psum_bias_rf #(
        .DATA_W (PSUM_W),
        .DEPTH  (FILTER_NUM)
    ) u_bias_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (bias_we),
        .waddr  (bias_addr),
        .wdata  (bias_data),
        .raddr  (filter_idx_q),
        .rdata  (bias_rd)
    );

    assign idx_max = IDX_W'(idx_max_for(cur_mode_q));
    assign valid   = (state_q == ST_SEND) && (op_stage_in == CONV);
    assign xfer    = valid && bus.psum_ack;
    assign restart = conv_continue || change_mode;

    // Sweep sequencing: restart beats a same-cycle transfer; filter index is the inner loop
    always_comb begin
        state_d      = state_q;
        filter_idx_d = filter_idx_q;
        psum_idx_d   = psum_idx_q;
        sweep_done_d = 1'b0;
        cur_mode_d   = change_mode ? mode_in : cur_mode_q;
        if (restart) begin
            state_d      = ST_SEND;
            filter_idx_d = '0;
            psum_idx_d   = '0;
        end else if (xfer) begin
            if (filter_idx_q == FILT_LAST) begin
                filter_idx_d = '0;
                if (psum_idx_q == idx_max) begin
                    state_d      = ST_DONE;
                    psum_idx_d   = '0;
                    sweep_done_d = 1'b1;
                end else begin
                    psum_idx_d = psum_idx_q + 1'b1;
                end
            end else begin
                filter_idx_d = filter_idx_q + 1'b1;
            end
        end
    end

    // State registers; reset abandons any sweep in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SEND;
            filter_idx_q <= '0;
            psum_idx_q   <= '0;
            cur_mode_q   <= MODE1;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            filter_idx_q <= filter_idx_d;
            psum_idx_q   <= psum_idx_d;
            cur_mode_q   <= cur_mode_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Packet assembly straight from the index registers, so it holds while stalled
    always_comb begin
        pkt            = '0;
        pkt.valid      = valid;
        pkt.filter_idx = PKG_FILT_W'(filter_idx_q);
        pkt.psum_idx   = PKG_IDX_W'(psum_idx_q);
        pkt.psum       = bias_en ? PKG_PSUM_W'(bias_rd) : '0;
    end

    assign bus.psum_out   = pkt;
    assign bus.sweep_done = sweep_done_q;
    assign bus.busy       = (state_q == ST_SEND);

endmodule
`default_nettype wire

// File: tb/tb_psum_init_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_init_gen
// Description : Scoreboard bench for psum_init_gen. Directed sequences push
//               expected packets; a negedge monitor pops and compares each
//               accepted packet.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_psum_init_gen;
    import psum_init_gen_pkg::*;

    localparam int FN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    OP_MODE      mode_in = MODE1;
    logic        change_mode = 1'b0;
    logic        conv_continue = 1'b0;
    OP_STAGE     op_stage_in = IDLE;
    logic        bias_en = 1'b0;
    logic        bias_we = 1'b0;
    logic [1:0]  bias_addr = 2'd0;
    logic [15:0] bias_data = 16'd0;

    psum_init_gen_if bus ();

    psum_init_gen #(.PSUM_W(16), .FILTER_NUM(FN), .IDX_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .mode_in       (mode_in),
        .change_mode   (change_mode),
        .conv_continue (conv_continue),
        .op_stage_in   (op_stage_in),
        .bias_en       (bias_en),
        .bias_we       (bias_we),
        .bias_addr     (bias_addr),
        .bias_data     (bias_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          xfer_cnt = 0;
    int          sweep_cnt = 0;
    bit          chk_stable = 1'b0;
    PSUM_PACKET  sb[$];
    logic [15:0] bias_model [FN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int first, input int n, input bit bias_on);
        PSUM_PACKET p;
        for (int k = first; k < first + n; k++) begin
            p            = '0;
            p.valid      = 1'b1;
            p.filter_idx = PKG_FILT_W'(k % FN);
            p.psum_idx   = PKG_IDX_W'(k / FN);
            p.psum       = bias_on ? bias_model[k % FN] : 16'd0;
            sb.push_back(p);
        end
    endtask

    // Monitor: every accepted packet is compared against the scoreboard head
    PSUM_PACKET prev_pkt;
    bit         prev_stall = 1'b0;
    always @(negedge clk) begin
        PSUM_PACKET e;
        if (!rst) begin
            if (bus.sweep_done) sweep_cnt++;
            if (chk_stable && prev_stall && bus.psum_out.valid)
                check("stall_stable", bus.psum_out, prev_pkt);
            prev_stall = chk_stable && bus.psum_out.valid && !bus.psum_ack;
            prev_pkt   = bus.psum_out;
            if (bus.psum_out.valid && bus.psum_ack) begin
                xfer_cnt++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pkt: got f=%0d i=%0d required none", bus.psum_out.filter_idx, bus.psum_out.psum_idx);
                end else begin
                    e = sb.pop_front();
                    check("pkt_filter", bus.psum_out.filter_idx, e.filter_idx);
                    check("pkt_idx",    bus.psum_out.psum_idx,   e.psum_idx);
                    check("pkt_psum",   bus.psum_out.psum,       e.psum);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_until_done(input int bound);
        int start = sweep_cnt;
        int n = 0;
        while (sweep_cnt == start && n < bound) begin
            tick();
            n++;
        end
        check("sweep_seen", (sweep_cnt != start), 1);
    endtask

    task automatic end_of_sweep(input int x0, input int s0, input int n_exp);
        check("sweep_xfers", xfer_cnt - x0, n_exp);
        check("sweep_pulses", sweep_cnt - s0, 1);
        check("sb_empty", sb.size(), 0);
        check("done_valid", bus.psum_out.valid, 0);
        check("done_busy", bus.busy, 0);
        repeat (3) tick();
        check("single_pulse", sweep_cnt - s0, 1);
        check("done_hold_valid", bus.psum_out.valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, s0;
        int n;
        bias_model[0] = 16'd5;
        bias_model[1] = 16'hFFFD;
        bias_model[2] = 16'd7;
        bias_model[3] = 16'd0;

        // Reset state
        bias_en = 1'b1;
        repeat (2) tick();
        check("rst_valid", bus.psum_out.valid, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_sweep_done", bus.sweep_done, 0);
        check("rst_filter", bus.psum_out.filter_idx, 0);
        check("rst_idx", bus.psum_out.psum_idx, 0);
        check("rst_psum", bus.psum_out.psum, 0);
        check("rst_mode", dut.cur_mode_q, MODE1);
        rst = 1'b0;
        bias_en = 1'b0;

        // Full MODE4 sweep with ack held high
        mode_in = MODE4; change_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        check("mode4_loaded", dut.cur_mode_q, MODE4);
        push_exp(0, FN * L3_OFMAP_SIZE, 1'b0);
        x0 = xfer_cnt; s0 = sweep_cnt;
        op_stage_in = CONV; bus.psum_ack = 1'b1;
        run_until_done(200);
        end_of_sweep(x0, s0, FN * L3_OFMAP_SIZE);

        // Stage leaves CONV mid-sweep: valid drops and indices freeze
        conv_continue = 1'b1; op_stage_in = IDLE;
        tick();
        conv_continue = 1'b0;
        push_exp(0, FN * L3_OFMAP_SIZE, 1'b0);
        x0 = xfer_cnt; s0 = sweep_cnt;
        op_stage_in = CONV;
        repeat (10) tick();
        op_stage_in = IDLE;
        repeat (5) begin
            tick();
            check("freeze_valid", bus.psum_out.valid, 0);
            check("freeze_filter", bus.psum_out.filter_idx, 2);
            check("freeze_idx", bus.psum_out.psum_idx, 2);
        end
        op_stage_in = CONV;
        #1;
        check("resume_valid", bus.psum_out.valid, 1);
        check("resume_filter", bus.psum_out.filter_idx, 2);
        check("resume_idx", bus.psum_out.psum_idx, 2);
        run_until_done(200);
        end_of_sweep(x0, s0, FN * L3_OFMAP_SIZE);

        // Bias write 5,-3,7,0 then sweeps with bias enabled and disabled
        op_stage_in = IDLE;
        for (int i = 0; i < FN; i++) begin
            bias_we = 1'b1; bias_addr = 2'(i); bias_data = bias_model[i];
            tick();
        end
        bias_we = 1'b0;
        bias_en = 1'b1;
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        push_exp(0, FN * L3_OFMAP_SIZE, 1'b1);
        x0 = xfer_cnt; s0 = sweep_cnt;
        op_stage_in = CONV;
        run_until_done(200);
        end_of_sweep(x0, s0, FN * L3_OFMAP_SIZE);
        bias_en = 1'b0;
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        push_exp(0, FN * L3_OFMAP_SIZE, 1'b0);
        x0 = xfer_cnt; s0 = sweep_cnt;
        run_until_done(200);
        end_of_sweep(x0, s0, FN * L3_OFMAP_SIZE);

        // change_mode to MODE3 coinciding with an ack at psum_idx 10
        op_stage_in = IDLE; mode_in = MODE1; change_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        push_exp(0, 41, 1'b0);
        op_stage_in = CONV;
        repeat (40) tick();
        check("pre_change_idx", bus.psum_out.psum_idx, 10);
        check("pre_change_filter", bus.psum_out.filter_idx, 0);
        s0 = sweep_cnt;
        mode_in = MODE3; change_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        push_exp(0, FN * L2_OFMAP_SIZE, 1'b0);
        x0 = xfer_cnt;
        check("chg_filter", bus.psum_out.filter_idx, 0);
        check("chg_idx", bus.psum_out.psum_idx, 0);
        check("chg_mode", dut.cur_mode_q, MODE3);
        check("chg_no_done", bus.sweep_done, 0);
        check("chg_no_pulse", sweep_cnt - s0, 0);
        run_until_done(300);
        end_of_sweep(x0, s0, FN * L2_OFMAP_SIZE);

        // Random back-pressure in MODE1
        op_stage_in = IDLE; bus.psum_ack = 1'b0; mode_in = MODE1; change_mode = 1'b1;
        tick();
        change_mode = 1'b0;
        push_exp(0, FN * L1_OFMAP_SIZE, 1'b0);
        x0 = xfer_cnt; s0 = sweep_cnt;
        chk_stable = 1'b1;
        op_stage_in = CONV;
        n = 0;
        while (sweep_cnt == s0 && n < 3000) begin
            bus.psum_ack = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk_stable = 1'b0;
        bus.psum_ack = 1'b1;
        check("bp_sweep_seen", (sweep_cnt != s0), 1);
        end_of_sweep(x0, s0, FN * L1_OFMAP_SIZE);

        // Reset mid-sweep after a bias write
        op_stage_in = IDLE;
        bias_we = 1'b1; bias_addr = 2'd1; bias_data = 16'd9;
        tick();
        bias_we = 1'b0;
        bias_model[1] = 16'd9;
        conv_continue = 1'b1;
        tick();
        conv_continue = 1'b0;
        bias_en = 1'b1;
        push_exp(0, 6, 1'b1);
        op_stage_in = CONV;
        repeat (6) tick();
        op_stage_in = IDLE; bus.psum_ack = 1'b0;
        s0 = sweep_cnt;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("mrst_filter", bus.psum_out.filter_idx, 0);
        check("mrst_idx", bus.psum_out.psum_idx, 0);
        check("mrst_sweep_done", bus.sweep_done, 0);
        check("mrst_busy", bus.busy, 1);
        check("mrst_mode", dut.cur_mode_q, MODE1);
        for (int i = 0; i < FN; i++) bias_model[i] = 16'd0;
        push_exp(0, FN, 1'b1);
        op_stage_in = CONV; bus.psum_ack = 1'b1;
        repeat (FN) tick();
        op_stage_in = IDLE; bus.psum_ack = 1'b0;
        tick();
        check("mrst_sb_empty", sb.size(), 0);
        check("mrst_no_pulse", sweep_cnt - s0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
